mprjram_arbiter: RTL

Two-port arbiter and sequencer for the user-project BRAM (`mprjram`) in `user_proj_example`. It shares one single-port BRAM between two requesters: the management-core Wishbone slave port, which fetches and executes firmware such as `matmul()` at 0x3800_0000, and a local accelerator port. It issues each access, counts out the fixed BRAM read latency, and returns a one-cycle acknowledge to the winner. Ties are resolved round-robin.

---
 rtl/mprjram_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mprjram_arbiter.sv
`timescale 1ns/1ps
// mprjram_arbiter
// ---------------------------------------------------------------------------
// Shares the single-port user-project BRAM between the management-core
// Wishbone slave port and a local accelerator port. Each granted access is
// issued for one cycle, the fixed BRAM read latency is counted out, and a
// one-cycle acknowledge goes back to the requester that won. Simultaneous
// requests are resolved round-robin against the previous owner.
//
// Ports
//   wb_clk_i / wb_rst_i      : clock, asynchronous active-high reset
//   wbs_cyc_i .. wbs_dat_i   : Wishbone classic slave inputs
//   wbs_ack_o / wbs_dat_o    : Wishbone acknowledge pulse and read data
//   acc_req .. acc_wdat      : accelerator level request, held until acc_ack
//   acc_ack / acc_rdat       : accelerator completion pulse and read data
//   bram_en .. bram_wdata    : BRAM enable, byte write enables, address, data
//   bram_rdata               : BRAM read data, valid RD_LAT cycles after bram_en
//   busy                     : high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module mprjram_arbiter #(
    parameter int         ADDR_W  = 10,
    parameter int         RD_LAT  = 2,
    parameter logic [7:0] BASE_HI = 8'h38
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic [ADDR_W-1:0] acc_adr,
    input  logic [31:0]       acc_wdat,
    output logic              acc_ack,
    output logic [31:0]       acc_rdat,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_wdata,
    input  logic [31:0]       bram_rdata,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic OWN_WB  = 1'b0;
    localparam logic OWN_ACC = 1'b1;

    // The counter is loaded in ISSUE; WAIT then lasts RD_LAT cycles.
    localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

    logic [1:0]        state_q,     state_d;
    logic              owner_q,     owner_d;
    logic              lastOwner_q, lastOwner_d;
    logic              write_q,     write_d;
    logic              abort_q,     abort_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic [3:0]        we_q,        we_d;
    logic [2:0]        cnt_q,       cnt_d;
    logic [31:0]       wbRdata_q,   wbRdata_d;
    logic [31:0]       accRdata_q,  accRdata_d;

    logic wbReq;
    logic grantWb;
    logic wbLost;
    logic unusedAdrBits;

    assign wbReq = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_HI);

    // Wishbone wins when it is alone, or on a tie when the accelerator
    // owned the previous transfer.
    assign grantWb = wbReq & (~acc_req | (lastOwner_q == OWN_ACC));

    // A Wishbone master that drops cyc mid-transfer has abandoned it; the
    // BRAM access still runs to completion so the sequencing stays simple.
    assign wbLost = (owner_q == OWN_WB) & ~wbs_cyc_i;

    assign unusedAdrBits = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

    // Next-state logic for the sequencer and all transaction registers.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        write_d     = write_q;
        abort_d     = abort_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        wbRdata_d   = wbRdata_q;
        accRdata_d  = accRdata_q;

        case (state_q)
            ST_IDLE: begin
                if (wbReq | acc_req) begin
                    state_d = ST_ISSUE;
                    abort_d = 1'b0;
                    if (grantWb) begin
                        owner_d = OWN_WB;
                        addr_d  = wbs_adr_i[ADDR_W+1:2];
                        wdata_d = wbs_dat_i;
                        write_d = wbs_we_i;
                        we_d    = wbs_we_i ? wbs_sel_i : 4'h0;
                    end else begin
                        owner_d = OWN_ACC;
                        addr_d  = acc_adr;
                        wdata_d = acc_wdat;
                        write_d = acc_we;
                        we_d    = acc_we ? 4'hF : 4'h0;
                    end
                end
            end
            ST_ISSUE: begin
                if (wbLost) begin
                    abort_d = 1'b1;
                end
                if (write_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (wbLost) begin
                    abort_d = 1'b1;
                end
                if (cnt_q == 3'd0) begin
                    state_d = ST_DONE;
                    if (owner_q == OWN_WB) begin
                        wbRdata_d = bram_rdata;
                    end else begin
                        accRdata_d = bram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                lastOwner_d = owner_q;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight access immediately.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_WB;
            lastOwner_q <= OWN_ACC;
            write_q     <= 1'b0;
            abort_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            we_q        <= 4'h0;
            cnt_q       <= 3'd0;
            wbRdata_q   <= 32'h0;
            accRdata_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
            write_q     <= write_d;
            abort_q     <= abort_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            wbRdata_q   <= wbRdata_d;
            accRdata_q  <= accRdata_d;
        end
    end

    // Outputs decode directly from registered state, so reset clears the
    // BRAM strobes in the same cycle it is asserted.
    assign bram_en    = (state_q == ST_ISSUE);
    assign bram_we    = bram_en ? we_q : 4'h0;
    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;

    assign wbs_ack_o = (state_q == ST_DONE) & (owner_q == OWN_WB) & ~abort_q;
    assign acc_ack   = (state_q == ST_DONE) & (owner_q == OWN_ACC);
    assign wbs_dat_o = wbRdata_q;
    assign acc_rdat  = accRdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
